memory_arbiter: RTL
===================

# memory_arbiter

Single-port memory arbiter sitting directly downstream of the per-CPU cache block. Accepts instruction-fetch and data read/write requests on the cache-control side, serializes them onto one RAM port, and returns per-request wait/ack and load data. Data accesses have priority over instruction fetches; an optional fairness counter bounds instruction starvation.

## Interface
- STARVE_MAX, default 4: consecutive data grants with a pending instruction request before the instruction side is forced next (fairness build only).
- CLK  in  1  clock, all state on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request, held until ack.
- iaddr  in  32  instruction byte address.
- dREN  in  1  data read request, held until ack.
- dWEN  in  1  data write request, held until ack.
- daddr  in  32  data byte address.
- dstore  in  32  data write value.
- iwait  out  1  low for exactly the ack cycle of an instruction grant, else high.
- dwait  out  1  low for exactly the ack cycle of a data grant, else high.
- iload  out  32  instruction read data, valid when iwait low.
- dload  out  32  data read data, valid when dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=00, BUSY=01, ACCESS=10, ERROR=11.
- memerr  out  1  sticky: set on any ERROR seen while granted.

## Operation
- FSM states: IDLE, DGRANT, IGRANT.
- IDLE: if dREN|dWEN -> DGRANT; else if iREN -> IGRANT; else stay. RAM enables low.
- DGRANT: ramaddr=daddr, ramstore=dstore; dWEN set -> ramWEN=1, ramREN=0 (WEN wins if both); else ramREN=1. On ramstate==ACCESS: dwait=0, dload=ramload, next IDLE.
- IGRANT: ramaddr=iaddr, ramREN=1. On ACCESS: iwait=0, iload=ramload, next IDLE.
- BUSY/FREE while granted: hold state and all RAM outputs stable.
- ERROR while granted: set memerr, no ack, return to IDLE (request still pending, re-arbitrated).
- Request withdrawn while granted (enable low): abandon, RAM enables low that cycle, next IDLE, no ack.
- iload/dload are 0 when the corresponding wait is high.
- Exactly one grant at a time; iwait and dwait never both low.

## Timing
- Reset values: state IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, memerr=0, starvation count 0.
- Request sampled in IDLE at edge N; RAM driven from cycle N+1; ack in the first cycle ramstate==ACCESS. Minimum request-to-ack: 2 cycles (request cycle + grant cycle with ACCESS).
- Ack is combinational from ramstate in the granted state; FSM leaves on the following edge, so back-to-back grants are separated by one IDLE cycle.
- Reset asserted mid-grant: all outputs go to reset values immediately (asynchronous), no ack issued.

## Configuration
- MEM_ARB_FAIR_EN defined: 3-bit-minimum counter increments on each data grant entered while iREN is high, clears on any instruction grant; when count == STARVE_MAX and iREN high, IDLE picks IGRANT even if data pending. Counter resets to 0.
- Undefined: strict data priority, no counter; instruction may starve indefinitely.

## Test plan
- Single read: iREN=1, iaddr=0x40, RAM returns ACCESS on first grant cycle with ramload=0xDEADBEEF -> iwait low exactly 1 cycle, iload=0xDEADBEEF, 2 cycles after request.
- Write with latency: dWEN=1, daddr=0x100, dstore=0x12345678, ramstate BUSY 3 cycles then ACCESS -> ramWEN/ramaddr/ramstore stable all 4 grant cycles, dwait low on cycle 5 only.
- Simultaneous iREN and dREN from IDLE -> DGRANT first; after ack and one IDLE cycle, IGRANT.
- ERROR on data grant -> memerr=1 and stays 1, no dwait pulse, request re-granted and completes on next ACCESS.
- nRST pulsed low during BUSY of an IGRANT -> all outputs at reset values the same cycle, no iwait pulse, FSM resumes from IDLE.
- MEM_ARB_FAIR_EN, STARVE_MAX=4, dREN and iREN held high continuously -> grant order D,D,D,D,I,D…; without macro, I never granted.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Serialises instruction-fetch and data read/write requests from the cache
//   side onto a single RAM port. Data requests win over instruction fetches.
//
//   Optional build macro: MEM_ARB_FAIR_EN
//     When defined, a starvation counter (parameter STARVE_MAX) forces an
//     instruction grant after STARVE_MAX consecutive data grants taken while
//     an instruction request was waiting. When undefined, data has strict
//     priority and STARVE_MAX does not exist.
//
//   Ports
//     CLK, nRST            clock (rising edge), async active-low reset
//     iREN, iaddr          instruction read request / byte address
//     dREN, dWEN           data read / write request (held until ack)
//     daddr, dstore        data byte address / write value
//     iwait, dwait         low only in the ack cycle of the matching grant
//     iload, dload         load data, zero whenever the matching wait is high
//     ramREN, ramWEN       RAM read / write enable
//     ramaddr, ramstore    RAM address / write data
//     ramload, ramstate    RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//     memerr               sticky flag, set when ERROR is seen while granted
module memory_arbiter
`ifdef MEM_ARB_FAIR_EN
#(
    parameter int unsigned STARVE_MAX = 4
)
`endif
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'b00,
        RAM_BUSY   = 2'b01,
        RAM_ACCESS = 2'b10,
        RAM_ERROR  = 2'b11
    } ramstate_t;

    state_t    r_state;
    state_t    w_next;
    ramstate_t w_ramst;
    logic      w_dreq;
    logic      w_force_i;
    logic      w_err;
    logic      r_memerr;

    assign w_ramst = ramstate_t'(ramstate);
    assign w_dreq  = dREN | dWEN;
    assign memerr  = r_memerr;

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

    logic [CW-1:0] r_starve;

    // Only an instruction request that is actually waiting may override data.
    assign w_force_i = iREN && (r_starve == CW'(STARVE_MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve <= '0;
        end else if (r_state == IDLE) begin
            if (w_next == IGRANT) begin
                r_starve <= '0;
            end else if (w_next == DGRANT && iREN && r_starve != CW'(STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
`else
    assign w_force_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_memerr <= 1'b0;
        end else if (w_err) begin
            r_memerr <= 1'b1;
        end
    end

    // Outputs are decoded from the state register so an asynchronous reset
    // forces every output to its reset value in the same cycle.
    always_comb begin
        w_next   = r_state;
        w_err    = 1'b0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (r_state)
            IDLE: begin
                if (w_force_i) begin
                    w_next = IGRANT;
                end else if (w_dreq) begin
                    w_next = DGRANT;
                end else if (iREN) begin
                    w_next = IGRANT;
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (w_ramst == RAM_ERROR) begin
                    w_err = 1'b1;
                end
                if (!w_dreq) begin
                    // Withdrawn request: drop enables now, no ack.
                    w_next = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = ~dWEN;
                    case (w_ramst)
                        RAM_ACCESS: begin
                            dwait  = 1'b0;
                            dload  = ramload;
                            w_next = IDLE;
                        end
                        RAM_ERROR: begin
                            w_next = IDLE;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                if (w_ramst == RAM_ERROR) begin
                    w_err = 1'b1;
                end
                if (!iREN) begin
                    w_next = IDLE;
                end else begin
                    ramREN = 1'b1;
                    case (w_ramst)
                        RAM_ACCESS: begin
                            iwait  = 1'b0;
                            iload  = ramload;
                            w_next = IDLE;
                        end
                        RAM_ERROR: begin
                            w_next = IDLE;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
